// File: rtl/gamepad_scan_seq_pkg.sv
// Shared definitions for the gamepad scan sequencer: pad width, FSM states, mux width helper.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package gamepad_scan_seq_pkg;

  localparam int PAD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_BUSY   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_COMMIT = 3'd5
  } scan_state_t;

  // Mux field width is max(1, clog2(data lines)) so a single-line reader still has a field.
  function automatic int mux_width(input int data_width);
    return ($clog2(data_width) < 1) ? 1 : $clog2(data_width);
  endfunction

endpackage

// File: rtl/gamepad_scan_seq_if.sv
// On-demand reader handshake: go pulse with sel/mux address, rdy/value return.
// Latency: combinational bundle, no storage.
// Backpressure: master may only pulse go while rdy is high; value is valid when rdy re-rises.
interface gamepad_scan_seq_if #(
  parameter int SEL_WIDTH = 1,
  parameter int MW        = 1
);
  import gamepad_scan_seq_pkg::*;

  logic                 od_go;
  logic [SEL_WIDTH-1:0] od_sel;
  logic [MW-1:0]        od_mux;
  logic                 od_rdy;
  logic [PAD_W-1:0]     od_value;

  modport master (output od_go, od_sel, od_mux, input od_rdy, od_value);
  modport slave  (input od_go, od_sel, od_mux, output od_rdy, od_value);

endinterface

// File: rtl/gamepad_scan_seq_timer.sv
// Free-running 0..PERIOD-1 counter producing a wrap flag on the last count.
// Latency: wrap is high during the cycle the counter holds PERIOD-1.
// Backpressure: none; the counter never stalls.
module gamepad_scan_seq_timer #(
  parameter int PERIOD = 200000
) (
  input  logic clk,
  input  logic rst,
  output logic o_wrap
);

  localparam int            CW   = (PERIOD < 2) ? 1 : $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_cnt;

  // Count up and fold back to zero after the last value of the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_wrap = (r_cnt == LAST);

endmodule

// File: rtl/gamepad_scan_seq.sv
// Walks every pad through the reader, stages the values, commits them atomically, tracks new presses.
// Latency: per pad reader time + 3 cycles; commit one cycle after the last pad is staged.
// Backpressure: holds in ISSUE until the reader is ready; extra scan requests collapse into one pending.
module gamepad_scan_seq
  import gamepad_scan_seq_pkg::*;
#(
  parameter  int SEL_WIDTH  = 1,
  parameter  int DATA_WIDTH = 2,
  parameter  int PERIOD     = 200000,
  localparam int MW         = mux_width(DATA_WIDTH),
  localparam int N_PADS     = DATA_WIDTH << SEL_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  gamepad_scan_seq_if.master        od,
  input  logic                      force_scan,
  input  logic [N_PADS*PAD_W-1:0]   press_clr,
  output logic [N_PADS*PAD_W-1:0]   pad_state,
  output logic [N_PADS*PAD_W-1:0]   pad_press,
  output logic                      scan_busy,
  output logic [7:0]                frame_cnt,
  output logic                      irq
);

  localparam int            IW       = SEL_WIDTH + MW;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PADS - 1);

  scan_state_t                       r_state;
  logic [IW-1:0]                     r_idx;
  logic                              r_pending;
  logic                              r_go;
  logic                              r_busy;
  logic [7:0]                        r_frame;
  logic                              r_irq;
  logic [N_PADS-1:0][PAD_W-1:0]      r_stage;
  logic [N_PADS*PAD_W-1:0]           r_pad_state;
  logic [N_PADS*PAD_W-1:0]           r_pad_press;

  logic                              w_wrap;
  logic                              w_req;
  logic [N_PADS*PAD_W-1:0]           w_stage_flat;

  gamepad_scan_seq_timer #(.PERIOD(PERIOD)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .o_wrap (w_wrap)
  );

  assign w_req        = w_wrap | force_scan;
  assign w_stage_flat = r_stage;

  // Address comes straight from the index register, so it is stable from ISSUE through WAIT.
  assign od.od_go  = r_go;
  assign od.od_sel = r_idx[MW +: SEL_WIDTH];
  assign od.od_mux = r_idx[0 +: MW];

  assign pad_state = r_pad_state;
  assign pad_press = r_pad_press;
  assign scan_busy = r_busy;
  assign frame_cnt = r_frame;
  assign irq       = r_irq;

  // Scan sequencer: request latch, per-pad handshake, staging, atomic commit and press tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_go        <= 1'b0;
      r_busy      <= 1'b0;
      r_frame     <= '0;
      r_irq       <= 1'b0;
      r_stage     <= '0;
      r_pad_state <= '0;
      r_pad_press <= '0;
    end else begin
      r_go  <= 1'b0;
      // irq follows the press register one cycle later.
      r_irq <= |r_pad_press;
      if (r_state != ST_COMMIT) begin
        r_pad_press <= r_pad_press & ~press_clr;
      end
      if (w_req) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_pending) begin
            // A request landing in the start cycle is folded into this scan.
            r_pending <= 1'b0;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (od.od_rdy) begin
            r_go    <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // rdy is still high in the go cycle, so it is not looked at here.
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (od.od_rdy) begin
            r_stage[r_idx] <= od.od_value;
            r_state        <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (r_idx == LAST_IDX) begin
            r_state <= ST_COMMIT;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_COMMIT: begin
          // A new press wins over a clear of the same bit in this cycle.
          r_pad_state <= w_stage_flat;
          r_pad_press <= (r_pad_press & ~press_clr) | (w_stage_flat & ~r_pad_state);
          r_frame     <= r_frame + 8'd1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
